// File: rtl/inst_sequencer.sv
// inst_sequencer: transmitting end of the 34-bit core instruction bus; runs one kernel pass.
// Define INST_SEQ_PAUSE_EN to add a pause input that freezes the inter-phase gap states.
module inst_sequencer #(
  parameter int          COL     = 8,
  parameter int          ROW     = 8,
  parameter int          LEN_NIJ = 36,
  parameter int          LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter int          GAP     = 10,
  parameter int          DRAIN   = ROW + COL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
`ifdef INST_SEQ_PAUSE_EN
  input  logic        pause,
`endif
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int CW = $clog2(LEN_NIJ + DRAIN + COL + GAP + 1);
  localparam logic [CW-1:0] C_COL      = CW'(COL);
  localparam logic [CW-1:0] C_NIJ      = CW'(LEN_NIJ);
  localparam logic [CW-1:0] C_GAP_END  = CW'(GAP - 1);
  localparam logic [CW-1:0] C_EXEC_END = CW'(LEN_NIJ + DRAIN - 1);
  localparam logic [3:0]    C_KIJ_LAST = 4'(LEN_KIJ - 1);
  localparam logic [33:0]   IDLE_WORD  = (34'd1 << 32) | (34'd1 << 31) | (34'd1 << 19) | (34'd1 << 18);

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_G1, S_LOAD, S_G2, S_AL0, S_G3, S_EXEC, S_OFRD, S_G4, S_NEXT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     kij_q, kij_d;
  logic [10:0]    paddr_q, paddr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [33:0]    inst_q, inst_d;
  logic           gap_hold;
  logic           pmem_wr;
  logic [10:0]    w_addr;

`ifdef INST_SEQ_PAUSE_EN
  assign gap_hold = pause;
`else
  assign gap_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    paddr_d = paddr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pmem_wr = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WL0;
        cnt_d   = '0;
        kij_d   = '0;
        paddr_d = '0;
        busy_d  = 1'b1;
      end
      S_WL0, S_LOAD: begin
        if (cnt_q == C_COL) begin
          state_d = (state_q == S_WL0) ? S_G1 : S_G2;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_G1, S_G2, S_G3, S_G4: if (!gap_hold) begin
        if (cnt_q == C_GAP_END) begin
          state_d = (state_q == S_G1) ? S_LOAD :
                    (state_q == S_G2) ? S_AL0  :
                    (state_q == S_G3) ? S_EXEC : S_NEXT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_AL0: begin
        if (cnt_q == C_NIJ) begin
          state_d = S_G3;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_EXEC: begin
        if (cnt_q == C_EXEC_END) begin
          state_d = S_OFRD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      // cnt_q counts pmem writes here; the final write is shown before leaving
      S_OFRD: begin
        if (cnt_q == C_NIJ) begin
          state_d = S_G4;
          cnt_d   = '0;
        end else if (ofifo_valid) begin
          pmem_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          paddr_d = paddr_q + 11'd1;
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (kij_q == C_KIJ_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          kij_d   = kij_q + 4'd1;
          state_d = S_WL0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // The registered word describes the state being entered, so it lines up with state_q.
    inst_d = IDLE_WORD;
    w_addr = W_BASE + 11'(int'(kij_d) * COL) + 11'(cnt_d);
    case (state_d)
      S_WL0: begin
        if (cnt_d < C_COL) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = w_addr;
        end
        inst_d[2] = (cnt_d != '0);
      end
      S_LOAD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = (cnt_d != '0);
      end
      S_AL0: begin
        if (cnt_d < C_NIJ) begin
          inst_d[19]   = 1'b0;
          inst_d[17:7] = 11'(cnt_d);
        end
        inst_d[2] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      default: ;
    endcase
    if (pmem_wr) begin
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = paddr_q;
      inst_d[6]     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      paddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= IDLE_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      paddr_q <= paddr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: directed bench for inst_sequencer; walks kij 0 cycle by cycle,
// then tracks pmem writes and kij steps for the rest of the pass. Honours INST_SEQ_PAUSE_EN.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
`ifdef INST_SEQ_PAUSE_EN
  logic        pause;
  localparam int G2_LEN = 30;
`else
  localparam int G2_LEN = 10;
`endif
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
`ifdef INST_SEQ_PAUSE_EN
    .pause       (pause),
`endif
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij         (kij)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [33:0] mkw(input logic cenx, input logic [10:0] ax, input logic l0wr,
                                      input logic l0rd, input logic ld, input logic ex);
    logic [33:0] w;
    w = '0;
    w[32] = 1'b1;
    w[31] = 1'b1;
    w[19] = cenx;
    w[18] = 1'b1;
    w[17:7] = ax;
    w[3] = l0rd;
    w[2] = l0wr;
    w[1] = ex;
    w[0] = ld;
    return w;
  endfunction

  function automatic logic [33:0] mkp(input logic [10:0] pa);
    logic [33:0] w;
    w = mkw(1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    w[32] = 1'b0;
    w[31] = 1'b0;
    w[30:20] = pa;
    w[6] = 1'b1;
    return w;
  endfunction

  // A_xmem is don't-care whenever xmem is disabled
  task automatic chk_word(input string tag, input logic [33:0] want);
    logic [33:0] mask;
    mask = '1;
    if (want[19]) mask[17:7] = '0;
    check(tag, 64'(inst & mask), 64'(want & mask));
  endtask

  // pmem-write scoreboard and kij progression, one line per write
  int         mon_pa = 0, mon_wr = 0, mon_done = 0, mon_steps = 0, last_pa = -1;
  int         pass_wr = 0, pass_last = -1;
  logic [3:0] mon_kij = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (!inst[32]) begin
        check("pmem_addr", 64'(inst[30:20]), 64'(mon_pa));
        check("pmem_wen", 64'(inst[31]), 64'd0);
        $display("pmem wr kij=%0d addr=%0d", kij, inst[30:20]);
        last_pa = int'(inst[30:20]);
        mon_pa++;
        mon_wr++;
      end
      if (done) begin
        mon_done++;
        pass_wr   = mon_wr;
        pass_last = last_pa;
      end
      if (!busy) begin
        mon_kij = '0;
        mon_pa  = 0;
        mon_wr  = 0;
      end else if (kij != mon_kij) begin
        check("kij_step", 64'(kij), 64'(mon_kij) + 64'd1);
        check("wr_per_kij", 64'(mon_wr), 64'(36 * int'(kij)));
        mon_kij = kij;
        mon_steps++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [33:0] idle_w;
    logic        prev;
    int          n_wr, exp_pa, guard, cyc;

    idle_w = mkw(1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
`ifdef INST_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_word("rst_inst", idle_w);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_kij", 64'(kij), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_word("idle_inst", idle_w);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("kij0", 64'(kij), 64'd0);

    for (int k = 0; k <= 8; k++) begin
      chk_word("wl0_kij0", (k < 8) ? mkw(1'b0, 11'h400 + 11'(k), k >= 1, 1'b0, 1'b0, 1'b0)
                                   : mkw(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      start = (k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk_word("g1_idle", idle_w);
      @(negedge clk);
    end
    for (int k = 0; k <= 8; k++) begin
      chk_word("load", mkw(1'b1, 11'd0, 1'b0, 1'b1, k >= 1, 1'b0));
      @(negedge clk);
    end
    for (int k = 0; k < G2_LEN; k++) begin
      chk_word("g2_idle", idle_w);
`ifdef INST_SEQ_PAUSE_EN
      if (k == 0) pause = 1'b1;
      if (k == 20) pause = 1'b0;
`endif
      @(negedge clk);
    end
    for (int k = 0; k <= 36; k++) begin
      chk_word("al0", (k < 36) ? mkw(1'b0, 11'(k), k >= 1, 1'b0, 1'b0, 1'b0)
                               : mkw(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      chk_word("g3_idle", idle_w);
      @(negedge clk);
    end
    for (int k = 0; k < 52; k++) begin
      chk_word("exec", mkw(1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1));
`ifdef INST_SEQ_PAUSE_EN
      if (k == 10) pause = 1'b1;
      if (k == 20) pause = 1'b0;
`endif
      @(negedge clk);
    end
    chk_word("exec_end", idle_w);

    // ofifo_valid toggles 1,0,1,...; the word shows the valid sampled one cycle earlier
    ofifo_valid = 1'b1;
    prev = 1'b1;
    @(negedge clk);
    n_wr = 0;
    exp_pa = 0;
    guard = 0;
    while (n_wr < 36 && guard < 200) begin
      if (prev) begin
        chk_word("ofrd_wr", mkp(11'(exp_pa)));
        n_wr++;
        exp_pa++;
      end else begin
        chk_word("ofrd_stall", idle_w);
      end
      ofifo_valid = ~ofifo_valid;
      prev = ofifo_valid;
      guard++;
      @(negedge clk);
    end
    check("ofrd_wr_count", 64'(n_wr), 64'd36);
    for (int k = 0; k < 11; k++) begin
      chk_word("g4_next_idle", idle_w);
      @(negedge clk);
    end
    check("kij1", 64'(kij), 64'd1);
    for (int k = 0; k <= 8; k++) begin
      chk_word("wl0_kij1", (k < 8) ? mkw(1'b0, 11'h408 + 11'(k), k >= 1, 1'b0, 1'b0, 1'b0)
                                   : mkw(1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
    end

    ofifo_valid = 1'b1;
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("done_kij", 64'(kij), 64'd8);
    check("done_busy", 64'(busy), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_once", 64'(done), 64'd0);
    check("busy_cleared", 64'(busy), 64'd0);
    chk_word("post_done_idle", idle_w);
    repeat (4) @(negedge clk);
    check("start_in_done_ignored", 64'(busy), 64'd0);
    check("pass_writes", 64'(pass_wr), 64'd324);
    check("pass_last_addr", 64'(pass_last), 64'd323);
    check("done_pulses", 64'(mon_done), 64'd1);
    check("kij_steps", 64'(mon_steps), 64'd8);

    // second pass, reset asynchronously in the middle of kij 1 execute
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(kij == 4'd1 && inst[1]) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("exec_kij1_reached", 64'(kij == 4'd1 && inst[1]), 64'd1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_word("rst_mid_inst", idle_w);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_kij", 64'(kij), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("no_resume_busy", 64'(busy), 64'd0);
    chk_word("no_resume_inst", idle_w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
